// File: rtl/risc_mc.sv
// risc_mc: multi-cycle accumulator processor with FETCH/DECODE/MEM/HALTED
// control and external memory behind a req/ack handshake (wait-state tolerant).
module risc_mc #(
   parameter int                AWIDTH   = 12,
   parameter int                DWIDTH   = 16,
   parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   output logic              halt,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [AWIDTH-1:0] pc_out,
   output logic [DWIDTH-1:0] acc_out
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_DECODE,
      S_MEM,
      S_HALTED
   } state_t;

   typedef enum logic [3:0] {
      OP_HLT = 4'h0,
      OP_SKZ = 4'h1,
      OP_ADD = 4'h2,
      OP_AND = 4'h3,
      OP_XOR = 4'h4,
      OP_LDA = 4'h5,
      OP_STO = 4'h6,
      OP_JMP = 4'h7,
      OP_SUB = 4'h8,
      OP_OR  = 4'h9,
      OP_SHL = 4'hA,
      OP_SHR = 4'hB,
      OP_LDI = 4'hC,
      OP_SKC = 4'hD,
      OP_NP0 = 4'hE,
      OP_NP1 = 4'hF
   } opcode_t;

   state_t              state, state_next;
   logic [AWIDTH-1:0]   pc;
   logic [DWIDTH-1:0]   acc;
   logic [DWIDTH-1:0]   ir;
   logic                c;
   logic                run;
   logic                req_active;
   logic                xfer;
   opcode_t             op;
   logic [AWIDTH-1:0]   ir_addr;
   logic [DWIDTH-1:0]   imm;
   logic [DWIDTH:0]     sum;
   logic [DWIDTH:0]     diff;
   logic                unused_ir;

   assign op      = opcode_t'(ir[DWIDTH-1 -: 4]);
   assign ir_addr = ir[AWIDTH-1:0];
   // Bits between the opcode and address fields carry no meaning.
   assign unused_ir = ^ir;

   // Carry/borrow come out as the extra top bit of a one-bit-wider result;
   // the borrow bit is set exactly when the operand exceeds acc (unsigned).
   assign sum  = {1'b0, acc} + {1'b0, mem_rdata};
   assign diff = {1'b0, acc} - {1'b0, mem_rdata};

   // Zero-extended immediate for LDI.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      imm              = '0;
      imm[AWIDTH-1:0]  = ir_addr;
   end

   // Requests only from the two bus-owning states, and only once out of reset,
   // so mem_req stays low for the whole reset period and depends on no input.
   assign req_active = run && (state == S_FETCH || state == S_MEM);
   assign xfer       = req_active && mem_ack;
   assign mem_req    = req_active;
   assign mem_wdata  = acc;
   assign pc_out     = pc;
   assign acc_out    = acc;

   // Run flag: releases the first FETCH request one cycle after reset ends.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) run <= 1'b0;
      else      run <= 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH;
      else      state <= state_next;
   end

   // Next-state and state-decoded bus/status outputs.
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      mem_addr   = pc;
      halt       = 1'b0;
      case (state)
         S_FETCH: begin
            if (xfer) state_next = S_DECODE;
         end
         S_DECODE: begin
            case (op)
               OP_HLT:                                    state_next = S_HALTED;
               OP_ADD, OP_AND, OP_XOR, OP_LDA,
               OP_STO, OP_SUB, OP_OR:                     state_next = S_MEM;
               default:                                   state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_addr = ir_addr;
            mem_we   = (op == OP_STO);
            if (xfer) state_next = S_FETCH;
         end
         S_HALTED: begin
            halt = 1'b1;
            if (go) state_next = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Architectural registers: IR/PC on fetch, single-cycle ops in DECODE,
   // memory-operand results on the MEM acknowledge edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc  <= RESET_PC;
         acc <= '0;
         c   <= 1'b0;
         ir  <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (xfer) begin
                  ir <= mem_rdata;
                  pc <= pc + AWIDTH'(1);
               end
            end
            S_DECODE: begin
               case (op)
                  OP_SKZ: if (acc == '0) pc <= pc + AWIDTH'(1);
                  OP_SKC: if (c)         pc <= pc + AWIDTH'(1);
                  OP_JMP: pc <= ir_addr;
                  OP_SHL: begin
                     c   <= acc[DWIDTH-1];
                     acc <= {acc[DWIDTH-2:0], 1'b0};
                  end
                  OP_SHR: begin
                     c   <= acc[0];
                     acc <= {1'b0, acc[DWIDTH-1:1]};
                  end
                  OP_LDI: acc <= imm;
                  default: ;
               endcase
            end
            S_MEM: begin
               if (xfer) begin
                  case (op)
                     OP_ADD: {c, acc} <= sum;
                     OP_SUB: {c, acc} <= diff;
                     OP_AND: acc <= acc & mem_rdata;
                     OP_OR:  acc <= acc | mem_rdata;
                     OP_XOR: acc <= acc ^ mem_rdata;
                     OP_LDA: acc <= mem_rdata;
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_risc_mc.sv
// Testbench for risc_mc: memory responder with programmable wait states,
// an instruction-level reference model checked on every bus transfer, and
// directed programs with hand-computed final results.
module tb_risc_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        go = 1'b0;
   logic        halt;
   logic        mem_req;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;
   logic        mem_ack = 1'b0;
   logic [11:0] pc_out;
   logic [15:0] acc_out;

   risc_mc #(.AWIDTH(12), .DWIDTH(16), .RESET_PC(12'h010)) dut (
      .clk(clk), .rst(rst), .go(go), .halt(halt),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .pc_out(pc_out), .acc_out(acc_out)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Environment memory and responder controls.
   logic [15:0] mem [4096];
   int          fetch_cyc [4096];
   int          waits    = 0;
   bit          spurious = 1'b0;

   // Instruction-level reference model.
   logic [11:0] m_pc;
   logic [15:0] m_acc;
   logic [15:0] m_ir;
   logic        m_c;
   bit          m_halted;
   bit          m_oper;

   task automatic model_reset();
      m_pc = 12'h010; m_acc = 16'h0; m_ir = 16'h0; m_c = 1'b0;
      m_halted = 1'b0; m_oper = 1'b0;
   endtask

   // Called for each completing transfer: the model predicts what the bus
   // access must be, then executes the instruction-level effect.
   task automatic model_xfer(input logic [11:0] addr, input logic we, input logic [15:0] wdata);
      logic [3:0]  op;
      logic [11:0] a;
      logic [15:0] v;
      logic [16:0] wide;
      if (m_halted) check("request while halted", {31'd0, mem_req}, 32'd0);
      if (!m_oper) begin
         check("fetch addr", {20'd0, addr}, {20'd0, m_pc});
         check("fetch we", {31'd0, we}, 32'd0);
         check("acc at fetch", {16'd0, acc_out}, {16'd0, m_acc});
         fetch_cyc[addr] = cyc;
         m_ir = mem[m_pc];
         m_pc = m_pc + 12'd1;
         op = m_ir[15:12];
         a  = m_ir[11:0];
         case (op)
            4'h0: m_halted = 1'b1;
            4'h1: if (m_acc == 16'h0) m_pc = m_pc + 12'd1;
            4'hD: if (m_c) m_pc = m_pc + 12'd1;
            4'h7: m_pc = a;
            4'hA: begin m_c = m_acc[15]; m_acc = m_acc << 1; end
            4'hB: begin m_c = m_acc[0];  m_acc = m_acc >> 1; end
            4'hC: m_acc = {4'h0, a};
            4'hE, 4'hF: ;
            default: m_oper = 1'b1;
         endcase
      end else begin
         op = m_ir[15:12];
         a  = m_ir[11:0];
         check("operand addr", {20'd0, addr}, {20'd0, a});
         check("operand we", {31'd0, we}, {31'd0, (op == 4'h6)});
         if (op == 4'h6) check("store data", {16'd0, wdata}, {16'd0, m_acc});
         else begin
            v = mem[a];
            case (op)
               4'h2: begin wide = m_acc + v; m_c = wide[16]; m_acc = wide[15:0]; end
               4'h8: begin m_c = (v > m_acc); m_acc = m_acc - v; end
               4'h3: m_acc = m_acc & v;
               4'h4: m_acc = m_acc ^ v;
               4'h5: m_acc = v;
               4'h9: m_acc = m_acc | v;
               default: ;
            endcase
         end
         m_oper = 1'b0;
      end
   endtask

   // Memory responder: drives ack/rdata on the falling edge, inserting
   // `waits` idle cycles before each ack, and checks request stability.
   int          wcnt    = 0;
   bit          waiting = 1'b0;
   logic [11:0] hold_addr;
   logic        hold_we;

   always @(negedge clk) begin
      logic prev_ack;
      prev_ack  = mem_ack;
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      if (!rst) begin
         wcnt = 0; waiting = 1'b0;
      end else begin
         if (prev_ack) begin wcnt = 0; waiting = 1'b0; end
         if (mem_req) begin
            if (waiting) check("req stable", {19'd0, mem_addr, mem_we}, {19'd0, hold_addr, hold_we});
            if (wcnt >= waits) begin
               mem_ack = 1'b1;
               if (!mem_we) mem_rdata = mem[mem_addr];
               model_xfer(mem_addr, mem_we, mem_wdata);
               if (mem_we) mem[mem_addr] = mem_wdata;
            end else begin
               wcnt++;
               waiting   = 1'b1;
               hold_addr = mem_addr;
               hold_we   = mem_we;
            end
         end else begin
            if (waiting) check("req held until ack", {31'd0, mem_req}, 32'd1);
            if (spurious) mem_ack = 1'b1;
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 16'h0000;
         fetch_cyc[i] = -1;
      end
   endtask

   task automatic enter_reset(input int w);
      rst = 1'b0;
      model_reset();
      waits = w;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_halt(output int hc);
      hc = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (halt) begin hc = cyc; break; end
      end
      check("halt reached", {31'd0, halt}, 32'd1);
      check("model halted", {31'd0, m_halted}, 32'd1);
   endtask

   task automatic load_prog_a();
      clear_mem();
      mem[12'h010] = 16'h5020;  // LDA 0x20
      mem[12'h011] = 16'h2021;  // ADD 0x21
      mem[12'h012] = 16'hD000;  // SKC
      mem[12'h013] = 16'h0000;  // HLT (skipped)
      mem[12'h014] = 16'h6022;  // STO 0x22
      mem[12'h015] = 16'h0000;  // HLT
      mem[12'h020] = 16'hFFFF;
      mem[12'h021] = 16'h0001;
      mem[12'h022] = 16'h1234;
   endtask

   initial begin
      int hc;
      bit quiet;

      // Reset state and first fetch.
      load_prog_a();
      enter_reset(0);
      check("reset mem_req", {31'd0, mem_req}, 32'd0);
      check("reset halt", {31'd0, halt}, 32'd0);
      check("reset pc_out", {20'd0, pc_out}, 32'h010);
      check("reset acc_out", {16'd0, acc_out}, 32'd0);
      release_reset();
      @(negedge clk);
      check("first req", {31'd0, mem_req}, 32'd1);
      check("first addr", {20'd0, mem_addr}, 32'h010);
      check("first we", {31'd0, mem_we}, 32'd0);

      // Arithmetic and carry, zero-wait memory.
      wait_halt(hc);
      check("A pc_out", {20'd0, pc_out}, 32'h016);
      check("A acc_out", {16'd0, acc_out}, 32'h0000);
      check("A model carry", {31'd0, m_c}, 32'd1);
      check("A mem[0x22]", {16'd0, mem[12'h022]}, 32'h0000);
      check("A ADD cycles", fetch_cyc[12'h012] - fetch_cyc[12'h011], 32'd3);
      check("A SKC cycles", fetch_cyc[12'h014] - fetch_cyc[12'h012], 32'd2);
      check("A HLT cycles", hc - fetch_cyc[12'h015], 32'd2);

      // Same program with 3 wait states per transfer.
      load_prog_a();
      enter_reset(3);
      release_reset();
      wait_halt(hc);
      check("D pc_out", {20'd0, pc_out}, 32'h016);
      check("D acc_out", {16'd0, acc_out}, 32'h0000);
      check("D mem[0x22]", {16'd0, mem[12'h022]}, 32'h0000);
      check("D ADD cycles", fetch_cyc[12'h012] - fetch_cyc[12'h011], 32'd9);
      check("D SKC cycles", fetch_cyc[12'h014] - fetch_cyc[12'h012], 32'd5);

      // Borrow and skip-on-zero.
      clear_mem();
      mem[12'h010] = 16'hC005;  // LDI 5
      mem[12'h011] = 16'h8030;  // SUB 0x30 (7)
      mem[12'h012] = 16'hD000;  // SKC
      mem[12'h014] = 16'h6031;  // STO 0x31
      mem[12'h015] = 16'hC000;  // LDI 0
      mem[12'h016] = 16'h1000;  // SKZ
      mem[12'h030] = 16'h0007;
      enter_reset(0);
      release_reset();
      wait_halt(hc);
      check("B mem[0x31]", {16'd0, mem[12'h031]}, 32'hFFFE);
      check("B pc_out", {20'd0, pc_out}, 32'h019);
      check("B acc_out", {16'd0, acc_out}, 32'h0000);

      // Shifts and logic ops; a go pulse while running must be ignored.
      clear_mem();
      mem[12'h010] = 16'h5040;  // LDA 0x40
      mem[12'h011] = 16'hA000;  // SHL
      mem[12'h012] = 16'hD000;  // SKC
      mem[12'h014] = 16'hB000;  // SHR
      mem[12'h015] = 16'hD000;  // SKC
      mem[12'h016] = 16'h9041;  // OR 0x41
      mem[12'h017] = 16'h4042;  // XOR 0x42
      mem[12'h018] = 16'h3043;  // AND 0x43
      mem[12'h019] = 16'h6044;  // STO 0x44
      mem[12'h01A] = 16'hB000;  // SHR
      mem[12'h040] = 16'h8001;
      mem[12'h041] = 16'h00F0;
      mem[12'h042] = 16'h0FFF;
      mem[12'h043] = 16'hF0FC;
      enter_reset(1);
      release_reset();
      repeat (3) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_halt(hc);
      check("C mem[0x44]", {16'd0, mem[12'h044]}, 32'h000C);
      check("C acc_out", {16'd0, acc_out}, 32'h0006);
      check("C pc_out", {20'd0, pc_out}, 32'h01C);

      // Halt and resume, with stray acks while halted.
      clear_mem();
      mem[12'h010] = 16'h7005;  // JMP 0x005
      mem[12'h006] = 16'hC123;  // LDI 0x123
      enter_reset(0);
      release_reset();
      wait_halt(hc);
      check("E halted pc_out", {20'd0, pc_out}, 32'h006);
      spurious = 1'b1;
      quiet = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (mem_req !== 1'b0 || halt !== 1'b1) quiet = 1'b0;
      end
      spurious = 1'b0;
      check("E idle while halted", {31'd0, quiet}, 32'd1);
      m_halted = 1'b0;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("E go req", {31'd0, mem_req}, 32'd1);
      check("E go addr", {20'd0, mem_addr}, 32'h006);
      wait_halt(hc);
      check("E acc_out", {16'd0, acc_out}, 32'h0123);
      check("E pc_out", {20'd0, pc_out}, 32'h008);

      // PC wrap from 0xFFF to 0x000.
      clear_mem();
      mem[12'h010] = 16'h7FFF;  // JMP 0xFFF
      mem[12'hFFF] = 16'hE000;  // NOP
      enter_reset(0);
      release_reset();
      wait_halt(hc);
      check("F wrap pc_out", {20'd0, pc_out}, 32'h001);
      check("F wrap fetch 0", {31'd0, (fetch_cyc[12'h000] > fetch_cyc[12'hFFF])}, 32'd1);

      // Asynchronous reset while a MEM transfer waits for ack.
      clear_mem();
      mem[12'h010] = 16'hC0AB;  // LDI 0xAB
      mem[12'h011] = 16'h5020;  // LDA 0x20
      mem[12'h020] = 16'h5555;
      enter_reset(5);
      release_reset();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 12'h020) break;
      end
      check("R in MEM", {20'd0, mem_addr}, 32'h020);
      check("R acc before", {16'd0, acc_out}, 32'h00AB);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("R mem_req", {31'd0, mem_req}, 32'd0);
      check("R halt", {31'd0, halt}, 32'd0);
      check("R pc_out", {20'd0, pc_out}, 32'h010);
      check("R acc_out", {16'd0, acc_out}, 32'h0000);
      waits = 0;
      repeat (2) @(negedge clk);
      release_reset();
      @(negedge clk);
      check("R restart addr", {20'd0, mem_addr}, 32'h010);
      wait_halt(hc);
      check("R final acc", {16'd0, acc_out}, 32'h5555);
      check("R final pc", {20'd0, pc_out}, 32'h013);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/risc_mc.md
# risc_mc

Parametrised multi-cycle accumulator processor, successor to the fixed 8-bit/5-bit eight-phase machine. Word and address widths are generic and the opcode field is widened to 4 bits, which adds SUB/OR/shift/immediate/carry-skip instructions and a carry flag. The fixed phase counter is replaced by a FETCH/DECODE/MEM state machine. Memory is external behind a req/ack handshake that tolerates wait states. A `go` input resumes execution after HLT.

## Interface
- AWIDTH, 12, address width; the address field is instruction bits [AWIDTH-1:0].
- DWIDTH, 16, data and instruction width. Opcode is bits [DWIDTH-1:DWIDTH-4]. DWIDTH ≥ AWIDTH+4 is required; bits between the two fields are ignored.
- RESET_PC, 0, PC value after reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle pulse; leaves HALTED. Ignored in all other states.
- halt  out  1  high while in HALTED.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  write qualifier; valid only while mem_req is high.
- mem_addr  out  AWIDTH  transfer address.
- mem_wdata  out  DWIDTH  write data; equals acc.
- mem_rdata  in  DWIDTH  read data; sampled on the edge where mem_ack=1.
- mem_ack  in  1  transfer completes on the rising edge where mem_req=1 and mem_ack=1.
- pc_out  out  AWIDTH  debug view of the PC.
- acc_out  out  DWIDTH  debug view of the accumulator.

## Operation
- ISA (hex opcode):
  - 0 HLT
  - 1 SKZ: skip the next instruction if acc==0.
  - 2 ADD
  - 3 AND
  - 4 XOR
  - 5 LDA
  - 6 STO
  - 7 JMP
  - 8 SUB
  - 9 OR
  - A SHL
  - B SHR
  - C LDI
  - D SKC: skip the next instruction if C==1.
  - E, F: NOP.
- Memory operand instructions (ADD, AND, XOR, LDA, STO, SUB, OR) use mem[IR addr].
- ALU rules:
  - ADD: {C,acc} = acc + mem.
  - SUB: acc = acc − mem; C = 1 when mem > acc (unsigned borrow).
  - SHL: C = acc[DWIDTH-1]; shift left, zero fill.
  - SHR: C = acc[0]; shift right, zero fill.
  - AND, OR, XOR, LDA: C unchanged.
  - LDI: acc = zero-extended IR[AWIDTH-1:0]; C unchanged.
  - STO: writes acc to memory; acc and C unchanged.
- PC arithmetic is modulo 2^AWIDTH, so PC increment and skip wrap from all-ones to 0.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ack: IR←mem_rdata, PC←PC+1, go to DECODE.
  - DECODE:
    - HLT → HALTED.
    - SKZ/SKC: if the condition holds, PC←PC+1. Then → FETCH.
    - JMP: PC←IR addr, → FETCH.
    - SHL/SHR/LDI/NOP: execute, → FETCH.
    - Memory operand instructions → MEM.
  - MEM: mem_req=1, mem_addr=IR addr, mem_we=1 for STO only. On ack: for loads and ALU ops, update acc/C from mem_rdata; for STO, the write is done. Then → FETCH.
  - HALTED: mem_req=0. `go` → FETCH. PC already points past the HLT.
- mem_req and mem_addr hold stable until ack. mem_req drops in the cycle after the ack edge unless the next state also requests: MEM→FETCH requests back-to-back with a new address.

## Timing
- Reset values (asserted immediately and asynchronously, including mid-transfer):
  - state=FETCH, PC=RESET_PC, acc=0, C=0, IR=0.
  - halt=0, mem_req=0 while rst is low.
  - mem_req rises in the first cycle after rst deasserts.
- Latency with zero-wait memory (ack in the same cycle as req):
  - ALU/LDA/STO: 3 cycles.
  - JMP, SKZ, SKC, SHL, SHR, LDI, NOP: 2 cycles.
  - HLT: 2 cycles to halt=1.
  - Each wait cycle adds 1.
- go → mem_req=1 on the next cycle.
- go asserted outside HALTED has no effect.
- mem_ack while mem_req=0 is ignored.
- Outputs are registered or decoded from state only; there is no combinational path from mem_ack to mem_req.

## Test plan
- Reset and first fetch: release rst with RESET_PC=0x010 → first request has mem_addr=0x010, mem_we=0; acc_out=0.
- Arithmetic and carry: mem[0x20]=0xFFFF, mem[0x21]=0x0001; program LDA 0x20, ADD 0x21, SKC, HLT, STO 0x22, HLT → acc=0, C=1, HLT skipped, write of 0x0000 to 0x22, halt=1.
- Borrow and skip: LDI 5, SUB mem=7 → acc=0xFFFE, C=1. Then LDI 0, SKZ → the next instruction is skipped and PC advances by 2.
- Wait states: mem_ack delayed 3 cycles on every transfer → identical architectural results. mem_req and mem_addr stay stable throughout, and ADD takes 9 cycles.
- Halt and resume: HLT at 0x005 → halt=1 and no requests for 10 cycles. Pulse go → fetch from 0x006.
- Wrap and async reset: JMP 0xFFF containing NOP → next fetch address is 0x000. Assert rst mid-MEM while ack is pending → mem_req=0 immediately and the state matches the reset values.
